// File: rtl/uart_hex_loader_pkg.sv
// Shared definitions for the UART hex loader.
//   - Receiver state encoding and state type
//   - ASCII control characters recognised by the decoder
//   - decode_nibble(): maps an ASCII hex digit to {valid, nibble}
package uart_hex_loader_pkg;

  typedef logic [2:0] rx_state_t;

  localparam rx_state_t ST_IDLE  = 3'd0;
  localparam rx_state_t ST_START = 3'd1;
  localparam rx_state_t ST_DATA  = 3'd2;
  localparam rx_state_t ST_STOP  = 3'd3;
  localparam rx_state_t ST_BREAK = 3'd4;

  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_ESC = 8'h1B;

  // Returns {1'b1, nibble} for 0-9 / A-F / a-f, otherwise 5'b0.
  // Letters have low nibble 1..6, so adding 9 gives 10..15 for both cases.
  function automatic logic [4:0] decode_nibble(input logic [7:0] b);
    logic [4:0] r;
    r = 5'b0;
    if (b >= 8'h30 && b <= 8'h39) begin
      r = {1'b1, b[3:0]};
    end else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66)) begin
      r = {1'b1, b[3:0] + 4'd9};
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_hex_loader_rx.sv
// 8N1 UART receiver with 2-FF input synchroniser.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   rx         in   asynchronous serial line, idle high
//   byte_valid out  1-cycle strobe, byte_data holds the received byte
//   byte_data  out  last received byte (LSB first assembly)
//   frame_err  out  1-cycle pulse, registered, after a low stop-bit sample
module uart_rx
  import uart_hex_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  logic [1:0]       settle_q, settle_d;
  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             fall;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    settle_d     = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;

    // The synchroniser comes out of reset holding 1s; rx_prev_q only carries
    // a real line sample after three clocks. Ignoring edges until then keeps a
    // line that is low at reset release from looking like a start bit.
    fall = (settle_q == 2'd3) && rx_prev_q && !rx_sync_q;

    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d = ST_START;
          cnt_d   = HALF_LOAD;
        end
      end
      ST_START: begin
        if (cnt_q == '0) begin
          if (!rx_sync_q) begin
            state_d   = ST_DATA;
            cnt_d     = FULL_LOAD;
            bit_idx_d = 3'd0;
          end else begin
            state_d = ST_IDLE;  // glitch, not a start bit
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rx_sync_q, shift_q[7:1]};
          cnt_d   = FULL_LOAD;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == '0) begin
          if (rx_sync_q) begin
            byte_valid_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_BREAK: begin
        if (rx_sync_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      settle_q     <= 2'd0;
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= 3'd0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      settle_q     <= settle_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Shift register is pure data; byte_valid qualifies it.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = shift_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/uart_hex_loader.sv
// Assembles ASCII hex characters from a UART line into a 16-bit display word.
// Digits shift into a shadow register; CR/LF copies it to data and pulses
// commit; ESC clears the shadow; anything else pulses bad_char.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   rx         in   asynchronous UART line, idle high, 8N1
//   data       out  committed display word
//   commit     out  1-cycle pulse, high in the first cycle data shows a new value
//   frame_err  out  1-cycle pulse on a low stop bit
//   bad_char   out  1-cycle pulse on an unrecognised byte
module uart_hex_loader
  import uart_hex_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [15:0] data,
  output logic        commit,
  output logic        frame_err,
  output logic        bad_char
);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic [4:0] dec;

  logic [15:0] shadow_q, shadow_d;
  logic [15:0] data_q, data_d;
  logic        commit_q, commit_d;
  logic        bad_char_q, bad_char_d;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  always_comb begin
    shadow_d   = shadow_q;
    data_d     = data_q;
    commit_d   = 1'b0;
    bad_char_d = 1'b0;
    dec        = decode_nibble(byte_data);
    if (byte_valid) begin
      if (dec[4]) begin
        shadow_d = {shadow_q[11:0], dec[3:0]};
      end else if (byte_data == ASCII_CR || byte_data == ASCII_LF) begin
        data_d   = shadow_q;
        commit_d = 1'b1;
        shadow_d = 16'h0000;
      end else if (byte_data == ASCII_ESC) begin
        shadow_d = 16'h0000;
      end else begin
        bad_char_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q   <= 16'h0000;
      data_q     <= 16'h0000;
      commit_q   <= 1'b0;
      bad_char_q <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      data_q     <= data_d;
      commit_q   <= commit_d;
      bad_char_q <= bad_char_d;
    end
  end

  assign data     = data_q;
  assign commit   = commit_q;
  assign bad_char = bad_char_q;

endmodule

// File: tb/tb_uart_hex_loader.sv
// Bench for uart_hex_loader: one instance at 16 clocks/bit, one at 4 clocks/bit
// for back-to-back frames. Expected pulses go into a per-instance queue when
// the byte is driven and are popped by a negedge monitor.
module tb_uart_hex_loader;
  import uart_hex_loader_pkg::*;

  localparam int CPB_A = 16;
  localparam int CPB_B = 4;

  localparam logic [1:0] EV_NONE   = 2'd0;
  localparam logic [1:0] EV_COMMIT = 2'd1;
  localparam logic [1:0] EV_BAD    = 2'd2;
  localparam logic [1:0] EV_FERR   = 2'd3;

  typedef struct {
    logic [1:0]  kind;
    logic [15:0] val;
  } ev_t;

  typedef struct {
    logic [7:0]  ch;
    logic [1:0]  kind;
    logic [15:0] val;  // data expected after this byte
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_a, rst_b, rx_a, rx_b;
  logic [15:0] data_a, data_b;
  logic        commit_a, commit_b, ferr_a, ferr_b, bad_a, bad_b;

  int checks = 0;
  int errors = 0;
  ev_t  q_a[$];
  ev_t  q_b[$];
  vec_t vecs[$];
  logic [15:0] last_d[2] = '{16'h0, 16'h0};

  always #5 clk = ~clk;

  uart_hex_loader #(.CLKS_PER_BIT(CPB_A)) dut_a (
    .clk(clk), .rst(rst_a), .rx(rx_a), .data(data_a),
    .commit(commit_a), .frame_err(ferr_a), .bad_char(bad_a)
  );

  uart_hex_loader #(.CLKS_PER_BIT(CPB_B)) dut_b (
    .clk(clk), .rst(rst_b), .rx(rx_b), .data(data_b),
    .commit(commit_b), .frame_err(ferr_b), .bad_char(bad_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mon(input int id, input logic c, input logic fe, input logic bc,
                     input logic r, input logic [15:0] d);
    int   n;
    logic [1:0] k;
    ev_t  e;
    logic got;
    n = int'(c) + int'(fe) + int'(bc);
    got = 1'b0;
    if (r) begin
      last_d[id] = d;
    end else begin
      if (n > 0) begin
        chk("pulse_exclusive", 32'(n > 1), 32'd0);
        k = c ? EV_COMMIT : (bc ? EV_BAD : EV_FERR);
        if (id == 0) begin
          if (q_a.size() > 0) begin e = q_a.pop_front(); got = 1'b1; end
        end else begin
          if (q_b.size() > 0) begin e = q_b.pop_front(); got = 1'b1; end
        end
        if (!got) begin
          chk("unexpected_pulse", 32'(k), 32'(EV_NONE));
        end else begin
          chk("pulse_kind", 32'(k), 32'(e.kind));
          if (k == EV_COMMIT) chk("commit_data", 32'(d), 32'(e.val));
        end
      end
      if (d !== last_d[id]) begin
        chk("data_change_without_commit", 32'(c), 32'd1);
        last_d[id] = d;
      end
    end
  endtask

  always @(negedge clk) mon(0, commit_a, ferr_a, bad_a, rst_a, data_a);
  always @(negedge clk) mon(1, commit_b, ferr_b, bad_b, rst_b, data_b);

  task automatic drive_rx(input int id, input logic v, input int cycles);
    if (id == 0) rx_a = v; else rx_b = v;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_byte(input int id, input logic [7:0] b, input logic stop_bit,
                           input int gap_bits);
    int cpb;
    cpb = (id == 0) ? CPB_A : CPB_B;
    drive_rx(id, 1'b0, cpb);
    for (int i = 0; i < 8; i++) drive_rx(id, b[i], cpb);
    drive_rx(id, stop_bit, cpb);
    if (gap_bits > 0) drive_rx(id, 1'b1, gap_bits * cpb);
  endtask

  task automatic send_exp(input int id, input logic [7:0] b, input logic [1:0] kind,
                          input logic [15:0] val, input int gap_bits);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    if (kind != EV_NONE) begin
      if (id == 0) q_a.push_back(e); else q_b.push_back(e);
    end
    send_byte(id, b, 1'b1, gap_bits);
  endtask

  function automatic void add(input logic [7:0] ch, input logic [1:0] kind,
                              input logic [15:0] val);
    vec_t v;
    v.ch = ch; v.kind = kind; v.val = val;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [7:0] ch7;
    ch7 = 8'h37;

    // "CAFE\r"
    add("C", EV_NONE, 16'h0000); add("A", EV_NONE, 16'h0000);
    add("F", EV_NONE, 16'h0000); add("E", EV_NONE, 16'h0000);
    add(8'h0D, EV_COMMIT, 16'hCAFE);
    // "12345\n": first digit falls off the top
    add("1", EV_NONE, 16'hCAFE); add("2", EV_NONE, 16'hCAFE);
    add("3", EV_NONE, 16'hCAFE); add("4", EV_NONE, 16'hCAFE);
    add("5", EV_NONE, 16'hCAFE); add(8'h0A, EV_COMMIT, 16'h2345);
    // "ab\r"
    add("a", EV_NONE, 16'h2345); add("b", EV_NONE, 16'h2345);
    add(8'h0D, EV_COMMIT, 16'h00AB);
    // "BE" ESC "EF\r"
    add("B", EV_NONE, 16'h00AB); add("E", EV_NONE, 16'h00AB);
    add(8'h1B, EV_NONE, 16'h00AB);
    add("E", EV_NONE, 16'h00AB); add("F", EV_NONE, 16'h00AB);
    add(8'h0D, EV_COMMIT, 16'h00EF);
    // "1G2\r": G is rejected and leaves the shadow alone
    add("1", EV_NONE, 16'h00EF); add("G", EV_BAD, 16'h00EF);
    add("2", EV_NONE, 16'h00EF); add(8'h0D, EV_COMMIT, 16'h0012);
    // empty commit
    add(8'h0A, EV_COMMIT, 16'h0000);

    rst_a = 1'b1; rst_b = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset_data_a", 32'(data_a), 32'h0);
    chk("reset_commit_a", 32'(commit_a), 32'h0);
    chk("reset_frame_err_a", 32'(ferr_a), 32'h0);
    chk("reset_bad_char_a", 32'(bad_a), 32'h0);
    chk("reset_data_b", 32'(data_b), 32'h0);
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (4 * CPB_A) @(negedge clk);

    foreach (vecs[i]) begin
      send_exp(0, vecs[i].ch, vecs[i].kind, vecs[i].val, 2);
      chk($sformatf("row%0d_pending", i), 32'(q_a.size()), 32'd0);
      chk($sformatf("row%0d_data", i), 32'(data_a), 32'(vecs[i].val));
    end

    // Framing error, then a long break, then normal traffic.
    q_a.push_back('{EV_FERR, 16'h0});
    send_byte(0, "5", 1'b0, 0);
    drive_rx(0, 1'b0, 30 * CPB_A);
    chk("ferr_pending", 32'(q_a.size()), 32'd0);
    chk("ferr_data_kept", 32'(data_a), 32'h0000);
    drive_rx(0, 1'b1, 3 * CPB_A);
    send_exp(0, "1", EV_NONE, 16'h0, 2);
    send_exp(0, 8'h0D, EV_COMMIT, 16'h0001, 2);
    chk("after_break_data", 32'(data_a), 32'h0001);

    // Short low glitch on an idle line.
    drive_rx(0, 1'b0, 3);
    drive_rx(0, 1'b1, 3 * CPB_A);
    chk("glitch_state_idle", 32'(dut_a.u_rx.state_q), 32'(ST_IDLE));
    chk("glitch_data_kept", 32'(data_a), 32'h0001);
    chk("glitch_pending", 32'(q_a.size()), 32'd0);

    // Reset in the middle of data bit 3 of '7' (that bit is 0: line low).
    drive_rx(0, 1'b0, CPB_A);
    for (int i = 0; i < 3; i++) drive_rx(0, ch7[i], CPB_A);
    drive_rx(0, ch7[3], CPB_A / 2);
    rst_a = 1'b1;
    repeat (3) @(negedge clk);
    chk("midframe_rst_data", 32'(data_a), 32'h0);
    rst_a = 1'b0;
    repeat (4 * CPB_A) @(negedge clk);
    chk("rst_line_low_state_idle", 32'(dut_a.u_rx.state_q), 32'(ST_IDLE));
    chk("rst_line_low_data", 32'(data_a), 32'h0);
    drive_rx(0, 1'b1, 3 * CPB_A);
    send_exp(0, "7", EV_NONE, 16'h0, 2);
    send_exp(0, 8'h0D, EV_COMMIT, 16'h0007, 2);
    chk("after_rst_data", 32'(data_a), 32'h0007);

    // Back-to-back frames with no idle gap at 4 clocks per bit.
    send_exp(1, "F", EV_NONE, 16'h0, 0);
    send_exp(1, "0", EV_NONE, 16'h0, 0);
    send_exp(1, "0", EV_NONE, 16'h0, 0);
    send_exp(1, "D", EV_NONE, 16'h0, 0);
    send_exp(1, 8'h0D, EV_COMMIT, 16'hF00D, 0);
    drive_rx(1, 1'b1, 10 * CPB_B);
    chk("b2b_pending", 32'(q_b.size()), 32'd0);
    chk("b2b_data", 32'(data_b), 32'hF00D);

    repeat (2 * CPB_A) @(negedge clk);
    chk("final_pending_a", 32'(q_a.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_hex_loader.md
# uart_hex_loader

Receives ASCII hex characters over a UART RX line and assembles them into the 16-bit word shown on the four-digit seven-segment display. It sits directly upstream of the hex display driver: its `data` output connects to the driver's `data` input, replacing the constant display word in the top level. Characters build up in a shadow register, and `data` changes only on a commit character, so the display never shows a partial entry.

## Interface

- `CLKS_PER_BIT`, default 5208: system clocks per UART bit (50 MHz / 9600 baud); legal range ≥ 4.
- `clk` in 1: system clock; sole clock domain.
- `rst` in 1: synchronous, active-high reset.
- `rx` in 1: UART receive line; asynchronous, idle high, 8N1, LSB first.
- `data` out 16: committed display word; reset 16'h0000.
- `commit` out 1: one-cycle pulse when `data` is updated; reset 0.
- `frame_err` out 1: one-cycle pulse when a stop bit is sampled low; reset 0.
- `bad_char` out 1: one-cycle pulse when a received byte is not a recognised character; reset 0.

## Operation

- `rx` passes through a 2-FF synchroniser (reset value 1) before any use.
- Receiver FSM states:
  - IDLE: on a synchronised falling edge, go to START and load the bit counter with `CLKS_PER_BIT/2 - 1`.
  - START: at count 0, sample the line. If low, go to DATA. If high, treat it as a glitch and return to IDLE with no pulse.
  - DATA: sample 8 bits, one every `CLKS_PER_BIT` clocks, each at mid-bit, shifting LSB first.
  - STOP: sample at mid-bit. If high, emit an internal `byte_valid` strobe for 1 cycle and go to IDLE. If low, pulse `frame_err`, discard the byte and go to BREAK.
  - BREAK: wait until the synchronised line reads high, then go to IDLE.
- Character decoder, applied on `byte_valid`:
  - `'0'-'9'` (0x30-0x39), `'A'-'F'` (0x41-0x46) and `'a'-'f'` (0x61-0x66) each map to a nibble. The shadow register updates as shadow ← {shadow[11:0], nibble}. Only the last 4 digits are kept; older digits fall off the top.
  - CR (0x0D) or LF (0x0A): `data` ← shadow, pulse `commit`, shadow ← 0. This happens even if no digits were received, in which case `data` becomes 0000.
  - ESC (0x1B): shadow ← 0. `data` is unchanged and there is no pulse.
  - Any other byte: pulse `bad_char`. Shadow and `data` are unchanged.
- Reset at any point, including mid-frame, returns the FSM to IDLE, clears shadow, `data` and all pulses, and sets the synchroniser flops to 1.
- A frame that was in progress when reset was released is not recovered. If the line is low when reset is released, there is no falling edge, so nothing is received until the line returns high and a new start bit arrives.

## Timing

- Decision points after the synchronised falling edge is detected:
  - Start-bit check: `CLKS_PER_BIT/2` clocks.
  - Data bit n (0-7): a further (n+1)·`CLKS_PER_BIT` clocks.
  - Stop bit: a further 9·`CLKS_PER_BIT` clocks.
- `byte_valid` is asserted in the cycle after the stop-bit sample.
- Decoder outputs (`data`, `commit`, `bad_char`, shadow) update registered, 1 cycle after `byte_valid`. `commit` is high in the same cycle `data` first shows the new value.
- `frame_err` is registered and asserted 1 cycle after the low stop-bit sample.
- Minimum byte spacing is 10 bit times; back-to-back frames with no idle gap must be received.
- The pulse outputs are mutually exclusive in any cycle.

## Structure

- Shared package holds:
  - Receiver state enum (IDLE, START, DATA, STOP, BREAK).
  - ASCII constants: CR 8'h0D, LF 8'h0A, ESC 8'h1B.
  - Nibble-decode function (byte → {valid, nibble}).
- One sub-module: `uart_rx`. It contains the synchroniser, the FSM and the bit counter, and outputs `byte_valid`, `byte_data[7:0]` and `frame_err`. `uart_hex_loader` holds the decoder, the shadow register and `data`.

## Test plan

- Send "CAFE\r" with `CLKS_PER_BIT`=16 → after the CR, `data`=16'hCAFE and `commit` is high exactly 1 cycle. No pulses appear before the CR, and `data` stays 0000 until the commit.
- Send "12345\n" → `data`=16'h2345 (the first digit is dropped). Then send "ab\r" → `data`=16'h00AB.
- Send "BE" then ESC then "EF\r" → `data`=16'h00EF. Sending "G" → `bad_char` pulses 1 cycle and shadow is unchanged.
- Send a frame with stop bit = 0 → `frame_err` pulses once and the byte is dropped. Hold the line low for 30 bit times → no further pulses. Release the line, then send "1\r" → `data`=16'h0001.
- Apply a 3-cycle low glitch on an idle line → no pulses and no state change. Assert `rst` during the 4th data bit of "7" → `data`=0 and the FSM is in IDLE. A following "7\r" → `data`=16'h0007.
- Send back-to-back frames "F00D\r" with zero idle gap at `CLKS_PER_BIT`=4 → `data`=16'hF00D.
